bram_read_arbiter: RTL and testbench
====================================

BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of read requesters, legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 10: BRAM word address width.
REQ-003 Parameter DATA_WIDTH, default 32: BRAM word width.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: reset, asynchronous and active-high.
REQ-006 Port en  input  1: grant enable; 0 blocks new grants.
REQ-007 Port req  input  NUM_REQ: per-requester read request level.
REQ-008 Port req_addr  input  NUM_REQ*ADDR_WIDTH: flattened addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port gnt  output  NUM_REQ: one-hot grant pulse in the accept cycle.
REQ-010 Port rsp_valid  output  NUM_REQ: one-hot pulse marking rsp_data valid for requester i.
REQ-011 Port rsp_data  output  DATA_WIDTH: read data shared by all requesters.
REQ-012 Port wr_valid / wr_addr / wr_data  input  1 / ADDR_WIDTH / DATA_WIDTH: host write (program load) request.
REQ-013 Port bram_r_valid / bram_r_addr  output  1 / ADDR_WIDTH: BRAM read port drive.
REQ-014 Port bram_r_data  input  DATA_WIDTH: BRAM registered read data, valid the cycle after bram_r_valid.
REQ-015 Port bram_w_valid / bram_w_addr / bram_w_data  output  1 / ADDR_WIDTH / DATA_WIDTH: BRAM write port drive.

Function
REQ-016 bram_w_valid/addr/data SHALL equal wr_valid/addr/data combinationally; writes are never stalled.
REQ-017 Requester i SHALL hold req[i] high and req_addr[i] stable until gnt[i]; the arbiter is not required to tolerate req[i] being dropped before gnt[i].
REQ-018 The arbiter SHALL grant at most one requester per cycle, combinationally from the current req, en and the priority pointer.
REQ-019 Arbitration SHALL be round-robin: search starts at index (last_gnt+1) mod NUM_REQ, wrapping, with the first asserted req winning.
REQ-020 last_gnt SHALL update to the granted index on the grant edge and hold otherwise.
REQ-021 Grant cycle: bram_r_valid=1, bram_r_addr=req_addr of the winner, gnt[winner]=1; in all other cycles bram_r_valid=0 and gnt=0.
REQ-022 Latency: rsp_valid[i] SHALL pulse exactly 1 cycle after gnt[i], with rsp_data=bram_r_data in that cycle.
REQ-023 Back-to-back grants SHALL be allowed every cycle; throughput is 1 read per cycle.
REQ-024 rsp_data SHALL hold the last read word when rsp_valid=0, because the BRAM updates its output only on a read.
REQ-025 Read/write collision: if wr_valid=1 and the winner's address equals wr_addr in the same cycle, no grant SHALL issue that cycle; last_gnt holds and the same winner is re-evaluated next cycle.
REQ-026 A collision SHALL block only the colliding cycle; it SHALL NOT cause a grant to a different requester in that cycle.
REQ-027 en=0 SHALL suppress all grants. A response already in flight SHALL still complete, with rsp_valid 1 cycle later.
REQ-028 Internal state: last_gnt (clog2(NUM_REQ) bits), rsp_tag (one-hot, NUM_REQ bits); rsp_valid = rsp_tag registered from gnt.

Reset
REQ-029 Asserting rst SHALL immediately set last_gnt=NUM_REQ-1 (requester 0 has first priority) and rsp_valid=0.
REQ-030 A grant issued in the cycle rst asserts SHALL produce no rsp_valid.
REQ-031 During rst, gnt=0 and bram_r_valid=0. bram_w_* pass-through SHALL remain active.
REQ-032 After rst deasserts, the first grant SHALL occur on the first rising edge with an eligible request.

Verification
REQ-033 Single request: req=0001, addr0=0x005, BRAM[5]=0xDEADBEEF -> gnt=0001 at cycle T, rsp_valid=0001 and rsp_data=0xDEADBEEF at T+1.
REQ-034 All four requesting continuously from reset -> grant order 0,1,2,3,0,1 on consecutive cycles, with rsp_valid following each grant by 1 cycle.
REQ-035 Wrap: last_gnt=3, req=1001 -> gnt=0001 next, then 1000.
REQ-036 Collision: req=0100, addr2=0x010, wr_valid=1, wr_addr=0x010, wr_data=0x12345678 -> no grant that cycle; gnt=0100 next cycle; rsp_data=0x12345678.
REQ-037 en toggle: en=0 with req=1111 -> no grants for 5 cycles; en=1 -> grants resume from (last_gnt+1).
REQ-038 Reset mid-stream: rst asserted the cycle after gnt[1] -> rsp_valid cleared immediately; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/bram_read_arbiter_if.sv
// Read-arbiter bundle: requester side, host write side and BRAM port side.
// slave = arbiter view; master = environment (requesters, host, BRAM) view.
interface bram_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                          en;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  logic                          wr_valid;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;

  logic                          bram_r_valid;
  logic [ADDR_WIDTH-1:0]         bram_r_addr;
  logic [DATA_WIDTH-1:0]         bram_r_data;
  logic                          bram_w_valid;
  logic [ADDR_WIDTH-1:0]         bram_w_addr;
  logic [DATA_WIDTH-1:0]         bram_w_data;

  modport slave (
    input  en, req, req_addr, wr_valid, wr_addr, wr_data, bram_r_data,
    output gnt, rsp_valid, rsp_data, bram_r_valid, bram_r_addr,
           bram_w_valid, bram_w_addr, bram_w_data
  );

  modport master (
    output en, req, req_addr, wr_valid, wr_addr, wr_data, bram_r_data,
    input  gnt, rsp_valid, rsp_data, bram_r_valid, bram_r_addr,
           bram_w_valid, bram_w_addr, bram_w_data
  );
endinterface

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port; grant is combinational, response 1 cycle later.
// Requesters wait (req held) while en=0 or on a write-address collision; host writes never stall.
module bram_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  bram_read_arbiter_if.slave bus
);
  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]      last_gnt_q, last_gnt_d;
  logic [NUM_REQ-1:0]    rsp_tag_q, rsp_tag_d;

  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  collide;
  logic [NUM_REQ-1:0]    gnt;

  always_comb begin
    int idx;
    found    = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    idx      = 0;
    // Search begins one past the last winner so every requester gets a turn.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found    = 1'b1;
        win_idx  = IDX_W'(idx);
        win_addr = bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end

    // A colliding winner stalls the whole cycle; nobody else is promoted.
    collide = found && bus.wr_valid && (win_addr == bus.wr_addr);

    gnt = '0;
    if (found && bus.en && !collide && !rst) begin
      gnt[win_idx] = 1'b1;
    end

    last_gnt_d = last_gnt_q;
    if (|gnt) begin
      last_gnt_d = win_idx;
    end
    rsp_tag_d = gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= LAST_RST;
      rsp_tag_q  <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

  assign bus.gnt          = gnt;
  assign bus.bram_r_valid = |gnt;
  assign bus.bram_r_addr  = win_addr;
  // The BRAM output register only changes on a read, so it already holds the last word.
  assign bus.rsp_valid    = rsp_tag_q;
  assign bus.rsp_data     = bus.bram_r_data;

  assign bus.bram_w_valid = bus.wr_valid;
  assign bus.bram_w_addr  = bus.wr_addr;
  assign bus.bram_w_data  = bus.wr_data;
endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: BRAM behavioural model, spec-level reference model
// compared every cycle, directed scenarios with literal expectations, then a constrained random run.
module tb_bram_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk;
  logic rst;

  bram_read_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // BRAM: registered read, output changes only when a read is issued.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (bus.bram_w_valid) mem[bus.bram_w_addr] <= bus.bram_w_data;
    if (bus.bram_r_valid) bus.bram_r_data <= mem[bus.bram_r_addr];
  end

  // Reference model state: priority pointer, expected response tag, last word read.
  int            m_last;
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [1024];

  always @(negedge clk) begin
    int            w;
    int            best;
    int            d;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    if (rst) begin
      m_last = N - 1;
      m_pend = '0;
    end
    // Winner = requesting index at the smallest round-robin distance past m_last.
    w    = -1;
    best = N;
    ea   = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (d < best) begin
          best = d;
          w    = i;
        end
      end
    end
    if (w >= 0) begin
      ea = bus.req_addr[w*AW +: AW];
      if (rst || !bus.en || (bus.wr_valid && bus.wr_addr == ea)) w = -1;
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;

    check("gnt", 64'(bus.gnt), 64'(eg));
    check("bram_r_valid", 64'(bus.bram_r_valid), 64'(w >= 0));
    if (w >= 0) check("bram_r_addr", 64'(bus.bram_r_addr), 64'(ea));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_pend));
    check("rsp_data", 64'(bus.rsp_data), 64'(m_rdata));
    check("bram_w_valid", 64'(bus.bram_w_valid), 64'(bus.wr_valid));
    if (bus.wr_valid) begin
      check("bram_w_addr", 64'(bus.bram_w_addr), 64'(bus.wr_addr));
      check("bram_w_data", 64'(bus.bram_w_data), 64'(bus.wr_data));
    end

    // Advance to what the next rising edge produces.
    if (!rst) begin
      m_pend = eg;
      if (w >= 0) begin
        m_last  = w;
        m_rdata = ref_mem[ea];
      end
    end
    if (bus.wr_valid) ref_mem[bus.wr_addr] = bus.wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  initial begin
    logic [N-1:0]    nreq;
    logic [N*AW-1:0] naddr;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hC0DE_0000 | DW'(i);
      ref_mem[i] = 32'hC0DE_0000 | DW'(i);
    end
    bus.bram_r_data = '0;
    m_rdata  = '0;
    m_last   = N - 1;
    m_pend   = '0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;

    // Reset state; host write passes through while in reset.
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 10'h005;
    bus.wr_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_gnt", 64'(bus.gnt), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_bram_w_valid", 64'(bus.bram_w_valid), 64'h1);
    check("rst_bram_w_data", 64'(bus.bram_w_data), 64'hDEAD_BEEF);
    tick();
    bus.wr_valid = 1'b0;
    rst = 1'b0;

    // Single request.
    tick();
    bus.en  = 1'b1;
    bus.req = 4'b0001;
    set_addr(0, 10'h005);
    @(negedge clk);
    check("single_gnt", 64'(bus.gnt), 64'b0001);
    check("single_raddr", 64'(bus.bram_r_addr), 64'h005);
    tick();
    bus.req = '0;
    @(negedge clk);
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'b0001);
    check("single_rsp_data", 64'(bus.rsp_data), 64'hDEAD_BEEF);

    // All four requesting from reset: 0,1,2,3,0,1.
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) set_addr(i, AW'(10'h040 + i));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_gnt", 64'(bus.gnt), 64'(1) << (i % 4));
      if (i > 0) check("rr_rsp_valid", 64'(bus.rsp_valid), 64'(1) << ((i - 1) % 4));
      tick();
    end

    // Wrap: bring last_gnt to 3, then req=1001.
    bus.req = 4'b1000;
    set_addr(3, 10'h033);
    @(negedge clk);
    check("rr_last_rsp", 64'(bus.rsp_valid), 64'b0010);
    check("wrap_pre_gnt", 64'(bus.gnt), 64'b1000);
    tick();
    bus.req = 4'b1001;
    set_addr(0, 10'h030);
    @(negedge clk);
    check("wrap_gnt0", 64'(bus.gnt), 64'b0001);
    tick();
    bus.req = 4'b1000;
    @(negedge clk);
    check("wrap_gnt3", 64'(bus.gnt), 64'b1000);

    // Collision on the winner; requester 3 must not be promoted.
    tick();
    bus.req = 4'b1100;
    set_addr(2, 10'h010);
    set_addr(3, 10'h020);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 10'h010;
    bus.wr_data  = 32'h1234_5678;
    @(negedge clk);
    check("coll_gnt", 64'(bus.gnt), 64'h0);
    check("coll_r_valid", 64'(bus.bram_r_valid), 64'h0);
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check("coll_next_gnt", 64'(bus.gnt), 64'b0100);
    check("coll_raddr", 64'(bus.bram_r_addr), 64'h010);
    tick();
    bus.req = 4'b1000;
    @(negedge clk);
    check("coll_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    check("coll_rsp_data", 64'(bus.rsp_data), 64'h1234_5678);
    check("coll_then_gnt3", 64'(bus.gnt), 64'b1000);

    // en low: no grants, in-flight response still completes.
    tick();
    bus.en  = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("en_off_gnt", 64'(bus.gnt), 64'h0);
      if (i == 0) check("en_off_inflight", 64'(bus.rsp_valid), 64'b1000);
      tick();
    end
    bus.en = 1'b1;
    @(negedge clk);
    check("en_on_gnt0", 64'(bus.gnt), 64'b0001);
    tick();
    @(negedge clk);
    check("en_on_gnt1", 64'(bus.gnt), 64'b0010);

    // Reset the cycle after gnt[1].
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("midrst_gnt", 64'(bus.gnt), 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_gnt", 64'(bus.gnt), 64'b0001);
    tick();
    bus.req = '0;

    // Random traffic; a request is only changed once it has been granted.
    nreq  = bus.req;
    naddr = bus.req_addr;
    repeat (300) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] || bus.gnt[i]) begin
          nreq[i]            = 1'($urandom_range(0, 1));
          naddr[i*AW +: AW]  = AW'($urandom_range(0, 15));
        end
      end
      tick();
      bus.req      = nreq;
      bus.req_addr = naddr;
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.wr_valid = ($urandom_range(0, 9) < 3);
      bus.wr_addr  = AW'($urandom_range(0, 15));
      bus.wr_data  = DW'($urandom);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
